dct_vecunrot_ram: RTL and testbench

- Inverse of the DCT vector-rotation reorder, used on the IDCT path.
- Accepts a paired stream of N/2+1 beats. Beat j carries F(j+1) on the primary lane and F(N+1-j) on the reversed lane; beats j=0 and j=N/2 carry the same value on both lanes.
- Rebuilds the natural-order N-point vector F(1)..F(N) in two half-size RAMs and emits it as a single-lane stream with Avalon-ST valid/ready.

---
 rtl/dct_pkg.sv | 16 +
 rtl/RAM_dct_vecRot.sv | 21 ++
 rtl/dct_unrot_skid.sv | 64 ++++++
 rtl/dct_vecunrot_ram.sv | 184 ++++++++++++++++++
 tb/tb_dct_vecunrot_ram.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dct_pkg.sv
// Shared definitions for the DCT vector reorder blocks: FSM encoding, RAM geometry
// and error codes.
package dct_pkg;

   typedef enum logic [1:0] {
      S_WAIT,
      S_WRITE,
      S_READ
   } dct_state_e;

   localparam int unsigned RAM_AW = 10;

   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_LEN  = 2'b01;

endpackage

// File: rtl/RAM_dct_vecRot.sv
// Simple dual-port RAM with a registered read, shared by the vector rotate/unrotate blocks.
module RAM_dct_vecRot #(
   parameter int W  = 32,
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          wren,
   input  logic [AW-1:0] wraddr,
   input  logic [W-1:0]  data,
   input  logic [AW-1:0] rdaddr,
   output logic [W-1:0]  q
);

   logic [W-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (wren) mem[wraddr] <= data;
      q <= mem[rdaddr];
   end

endmodule

// File: rtl/dct_unrot_skid.sv
// Two-entry valid/ready output buffer; head entry drives the outputs directly so they
// only move on a pop or when the buffer is empty.
module dct_unrot_skid #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   input  logic         in_sop,
   input  logic         in_eop,
   input  logic [1:0]   in_error,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         out_sop,
   output logic         out_eop,
   output logic [1:0]   out_error,
   output logic [1:0]   count
);

   localparam int EW = W + 4;

   logic [EW-1:0] e0_q, e1_q, in_ent;
   logic [1:0]    cnt_q;
   logic          pop;

   assign in_ent    = {in_data, in_sop, in_eop, in_error};
   assign pop       = (cnt_q != 2'd0) & out_ready;
   assign out_valid = (cnt_q != 2'd0);
   assign count     = cnt_q;
   assign {out_data, out_sop, out_eop, out_error} = e0_q;

   // The producer throttles itself on count, so a push never meets a full buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e0_q  <= '0;
         e1_q  <= '0;
         cnt_q <= 2'd0;
      end else begin
         case ({in_valid, pop})
            2'b10: begin
               if (cnt_q == 2'd0) e0_q <= in_ent;
               else               e1_q <= in_ent;
               cnt_q <= cnt_q + 2'd1;
            end
            2'b01: begin
               e0_q  <= e1_q;
               cnt_q <= cnt_q - 2'd1;
            end
            2'b11: begin
               if (cnt_q == 2'd1) begin
                  e0_q <= in_ent;
               end else begin
                  e0_q <= e1_q;
                  e1_q <= in_ent;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/dct_vecunrot_ram.sv
// Inverse of the DCT vector-rotation reorder: collects a paired N/2+1 beat stream into two
// half-size RAMs and replays it as the natural-order N-point single-lane stream.
module dct_vecunrot_ram
   import dct_pkg::*;
#(
   parameter int wDataIn  = 16,
   parameter int wDataOut = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                sink_valid,
   output logic                sink_ready,
   input  logic [1:0]          sink_error,
   input  logic                sink_sop,
   input  logic                sink_eop,
   input  logic [wDataIn-1:0]  sink_real,
   input  logic [wDataIn-1:0]  sink_imag,
   input  logic [wDataIn-1:0]  sink_real_rev,
   input  logic [wDataIn-1:0]  sink_imag_rev,
   input  logic [11:0]         fftpts_in,
   output logic                source_valid,
   input  logic                source_ready,
   output logic [1:0]          source_error,
   output logic                source_sop,
   output logic                source_eop,
   output logic [wDataOut-1:0] source_real,
   output logic [wDataOut-1:0] source_imag,
   output logic [11:0]         fftpts_out
);

   localparam int DW = 2 * wDataIn;

   dct_state_e        state_q, state_d;
   logic [11:0]       n_q;
   logic [10:0]       half_q, j_q, j_d;
   logic              err_q, err_d, latch_n, sink_ready_q, accept;
   logic              wr0, wr1;
   logic [RAM_AW-1:0] wa0, wa1, ra0, ra1;
   logic [DW-1:0]     q0, q1, skid_data;
   logic [11:0]       rd_idx_q;
   logic              rd_done_q, rd_issue, rd_upper;
   logic              rd_vld_q, rd_sel_q, rd_sop_q, rd_eop_q;
   logic [1:0]        skid_cnt;
   logic [2:0]        occ_next;
   logic              pop;
   logic              unused_sink_error;

   assign unused_sink_error = ^sink_error;
   assign sink_ready        = sink_ready_q;
   assign accept            = sink_valid & sink_ready_q;
   assign fftpts_out        = n_q;

   always_comb begin
      state_d = state_q;
      j_d     = j_q;
      err_d   = err_q;
      latch_n = 1'b0;
      wr0     = 1'b0;
      wr1     = 1'b0;
      wa0     = '0;
      wa1     = '0;
      case (state_q)
         S_WAIT, S_WRITE: begin
            if (accept && sink_sop) begin
               // A sop always restarts collection, even mid-packet.
               latch_n = 1'b1;
               err_d   = sink_eop;
               j_d     = 11'd1;
               wr0     = 1'b1;
               state_d = sink_eop ? S_READ : S_WRITE;
            end else if (accept && state_q == S_WRITE) begin
               j_d = j_q + 11'd1;
               if (j_q < half_q) begin
                  wr0 = 1'b1;
                  wa0 = j_q[RAM_AW-1:0];
               end
               wr1 = 1'b1;
               wa1 = half_q[RAM_AW-1:0] - j_q[RAM_AW-1:0];
               if (sink_eop != (j_q == half_q)) err_d = 1'b1;
               // Reaching N/2 closes the packet whether or not eop came with it.
               if (sink_eop || j_q == half_q) state_d = S_READ;
            end
         end
         S_READ: begin
            if (pop && source_eop) state_d = S_WAIT;
         end
         default: state_d = S_WAIT;
      endcase
   end

   assign rd_upper = rd_idx_q >= {1'b0, half_q};
   assign ra0      = rd_idx_q[RAM_AW-1:0];
   assign ra1      = rd_idx_q[RAM_AW-1:0] - half_q[RAM_AW-1:0];
   assign pop      = source_valid & source_ready;
   // Issue only if the skid can still absorb this read one cycle from now.
   assign occ_next = {1'b0, skid_cnt} + {2'b00, rd_vld_q} - {2'b00, pop};
   assign rd_issue = (state_q == S_READ) & ~rd_done_q & (occ_next <= 3'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_WAIT;
         n_q          <= '0;
         half_q       <= '0;
         j_q          <= '0;
         err_q        <= 1'b0;
         sink_ready_q <= 1'b0;
         rd_idx_q     <= '0;
         rd_done_q    <= 1'b0;
         rd_vld_q     <= 1'b0;
         rd_sel_q     <= 1'b0;
         rd_sop_q     <= 1'b0;
         rd_eop_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         j_q          <= j_d;
         err_q        <= err_d;
         sink_ready_q <= (state_d != S_READ);
         if (latch_n) begin
            n_q    <= fftpts_in;
            half_q <= fftpts_in[11:1];
         end
         rd_vld_q <= rd_issue;
         if (rd_issue) begin
            rd_sel_q <= rd_upper;
            rd_sop_q <= (rd_idx_q == 12'd0);
            rd_eop_q <= (rd_idx_q == n_q - 12'd1);
         end
         if (state_q != S_READ) begin
            rd_idx_q  <= '0;
            rd_done_q <= 1'b0;
         end else if (rd_issue) begin
            rd_idx_q <= rd_idx_q + 12'd1;
            if (rd_idx_q == n_q - 12'd1) rd_done_q <= 1'b1;
         end
      end
   end

   RAM_dct_vecRot #(
      .W  (DW),
      .AW (RAM_AW)
   ) u_ram0 (
      .clk    (clk),
      .wren   (wr0),
      .wraddr (wa0),
      .data   ({sink_real, sink_imag}),
      .rdaddr (ra0),
      .q      (q0)
   );

   RAM_dct_vecRot #(
      .W  (DW),
      .AW (RAM_AW)
   ) u_ram1 (
      .clk    (clk),
      .wren   (wr1),
      .wraddr (wa1),
      .data   ({sink_real_rev, sink_imag_rev}),
      .rdaddr (ra1),
      .q      (q1)
   );

   dct_unrot_skid #(
      .W (DW)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (rd_vld_q),
      .in_data   (rd_sel_q ? q1 : q0),
      .in_sop    (rd_sop_q),
      .in_eop    (rd_eop_q),
      .in_error  (err_q ? ERR_LEN : ERR_NONE),
      .out_valid (source_valid),
      .out_ready (source_ready),
      .out_data  (skid_data),
      .out_sop   (source_sop),
      .out_eop   (source_eop),
      .out_error (source_error),
      .count     (skid_cnt)
   );

   assign source_real = skid_data[DW-1:wDataIn];
   assign source_imag = skid_data[wDataIn-1:0];

endmodule

// File: tb/tb_dct_vecunrot_ram.sv
// Self-checking bench for dct_vecunrot_ram against a RAM-level reference model.
module tb_dct_vecunrot_ram;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sink_valid, sink_ready, sink_sop, sink_eop;
   logic [1:0]  sink_error;
   logic [15:0] sink_real, sink_imag, sink_real_rev, sink_imag_rev;
   logic [11:0] fftpts_in, fftpts_out;
   logic        source_valid, source_ready, source_sop, source_eop;
   logic [1:0]  source_error;
   logic [15:0] source_real, source_imag;

   always #5 clk = ~clk;

   dct_vecunrot_ram #(
      .wDataIn  (16),
      .wDataOut (16)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .sink_valid    (sink_valid),
      .sink_ready    (sink_ready),
      .sink_error    (sink_error),
      .sink_sop      (sink_sop),
      .sink_eop      (sink_eop),
      .sink_real     (sink_real),
      .sink_imag     (sink_imag),
      .sink_real_rev (sink_real_rev),
      .sink_imag_rev (sink_imag_rev),
      .fftpts_in     (fftpts_in),
      .source_valid  (source_valid),
      .source_ready  (source_ready),
      .source_error  (source_error),
      .source_sop    (source_sop),
      .source_eop    (source_eop),
      .source_real   (source_real),
      .source_imag   (source_imag),
      .fftpts_out    (fftpts_out)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Packet under construction: natural-order vector and the paired beats built from it.
   logic [15:0] f_re [1:2048];
   logic [15:0] f_im [1:2048];
   logic [15:0] b_re [0:1024];
   logic [15:0] b_im [0:1024];
   logic [15:0] b_rre [0:1024];
   logic [15:0] b_rim [0:1024];
   logic        b_sop [0:1024];
   logic        b_eop [0:1024];
   int          nb, pk_n;

   // Reference model: the two half-size memories plus packet bookkeeping.
   logic [31:0] m0 [0:1023];
   logic [31:0] m1 [0:1023];
   int          m_n = 0, m_half = 0, m_j = 0;
   bit          m_act = 0, m_err = 0;

   task automatic build(input int n, input bit rnd);
      for (int k = 1; k <= n; k++) begin
         f_re[k] = rnd ? 16'($urandom) : 16'(k);
         f_im[k] = rnd ? 16'($urandom) : 16'(-k);
      end
      nb   = n / 2 + 1;
      pk_n = n;
      for (int j = 0; j < nb; j++) begin
         b_re[j]  = f_re[j+1];
         b_im[j]  = f_im[j+1];
         b_rre[j] = (j == 0) ? f_re[1] : f_re[n+1-j];
         b_rim[j] = (j == 0) ? f_im[1] : f_im[n+1-j];
         b_sop[j] = (j == 0);
         b_eop[j] = (j == n / 2);
      end
   endtask

   task automatic model_beat(input int j);
      if (b_sop[j]) begin
         m_n = pk_n; m_half = pk_n / 2; m_j = 0; m_err = 0; m_act = 1;
      end
      if (m_act) begin
         if (m_j < m_half) m0[m_j] = {b_re[j], b_im[j]};
         if (m_j >= 1) m1[m_half-m_j] = {b_rre[j], b_rim[j]};
         if (b_eop[j] != (m_j == m_half)) m_err = 1;
         if (b_eop[j] || m_j == m_half) m_act = 0;
         m_j++;
      end
   endtask

   task automatic send(input int from, input int upto);
      for (int j = from; j < upto; j++) begin
         int w;
         @(negedge clk);
         sink_valid    = 1'b1;
         sink_sop      = b_sop[j];
         sink_eop      = b_eop[j];
         sink_real     = b_re[j];
         sink_imag     = b_im[j];
         sink_real_rev = b_rre[j];
         sink_imag_rev = b_rim[j];
         fftpts_in     = 12'(pk_n);
         w = 0;
         while (!sink_ready && w < 200) begin
            @(negedge clk);
            w++;
         end
         n_tests++;
         if (sink_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_ready beat %0d: sink_ready=%b required 1", j, sink_ready);
         end
         @(posedge clk);
         if (sink_ready === 1'b1) model_beat(j);
      end
      #1;
      sink_valid = 1'b0;
      sink_sop   = 1'b0;
      sink_eop   = 1'b0;
   endtask

   // mode 0: ready held high (gaps checked); 1: 1010.. with a 5-cycle stall; 2: random
   task automatic collect(input int nbeats, input int mode, input string nm);
      int          idx = 0, cyc = 0, stall = 5, limit;
      int          bad_gap = 0, bad_hold = 0, bad_sr = 0;
      bit          held = 0, started = 0;
      logic [31:0] hd, exp_d;
      logic        hs = 0, he = 0;
      logic [1:0]  exp_e;
      limit = nbeats * 4 + 200;
      exp_e = m_err ? 2'b01 : 2'b00;
      while (idx < nbeats && cyc < limit) begin
         @(negedge clk);
         cyc++;
         if (held && !(source_valid === 1'b1 && {source_real, source_imag} === hd &&
                       source_sop === hs && source_eop === he)) bad_hold++;
         if (mode == 1) begin
            if (idx == 4 && stall > 0) begin
               source_ready = 1'b0;
               stall--;
            end else begin
               source_ready = (cyc % 2) == 1;
            end
         end else if (mode == 2) begin
            source_ready = 1'($urandom_range(0, 1));
         end else begin
            source_ready = 1'b1;
         end
         if (sink_ready !== 1'b0) bad_sr++;
         if (mode == 0 && started && source_valid !== 1'b1) bad_gap++;
         held = (source_valid === 1'b1) && !source_ready;
         hd   = {source_real, source_imag};
         hs   = source_sop;
         he   = source_eop;
         if (source_valid === 1'b1 && source_ready) begin
            exp_d = (idx < m_half) ? m0[idx] : m1[idx-m_half];
            n_tests++;
            if ({source_real, source_imag} !== exp_d || source_sop !== (idx == 0) ||
                source_eop !== (idx == m_n - 1) || source_error !== exp_e ||
                fftpts_out !== 12'(m_n)) begin
               n_fail++;
               $display("FAIL %s beat %0d: got data=%h sop=%b eop=%b err=%b n=%0d, required data=%h sop=%b eop=%b err=%b n=%0d",
                        nm, idx, {source_real, source_imag}, source_sop, source_eop,
                        source_error, fftpts_out, exp_d, idx == 0, idx == m_n - 1,
                        exp_e, m_n);
            end
            started = 1;
            idx++;
         end
      end
      n_tests++;
      if (idx != nbeats) begin
         n_fail++;
         $display("FAIL %s count: got %0d beats, required %0d", nm, idx, nbeats);
      end
      n_tests++;
      if (bad_gap != 0 || bad_hold != 0 || bad_sr != 0) begin
         n_fail++;
         $display("FAIL %s stream: gaps=%0d unstable_holds=%0d sink_ready_high=%0d, required all 0",
                  nm, bad_gap, bad_hold, bad_sr);
      end
   endtask

   task automatic post_check(input string nm);
      @(negedge clk);
      @(negedge clk);
      n_tests++;
      if (source_valid !== 1'b0 || sink_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s idle: source_valid=%b sink_ready=%b, required 0 and 1",
                  nm, source_valid, sink_ready);
      end
   endtask

   task automatic check_zero(input string nm);
      n_tests++;
      if ({source_valid, source_sop, source_eop, source_error, source_real, source_imag,
           fftpts_out, sink_ready} !== '0) begin
         n_fail++;
         $display("FAIL %s outputs: valid=%b sop=%b eop=%b err=%b re=%h im=%h n=%h ready=%b, required all 0",
                  nm, source_valid, source_sop, source_eop, source_error, source_real,
                  source_imag, fftpts_out, sink_ready);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_tests++;
      if (sink_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release: sink_ready=%b required 1", sink_ready);
      end
   endtask

   task automatic test_basic();
      build(8, 0);
      source_ready = 1'b1;
      send(0, nb);
      @(posedge clk);
      #1;
      n_tests++;
      if (source_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL latency_early: source_valid=%b one cycle after eop, required 0", source_valid);
      end
      @(posedge clk);
      #1;
      n_tests++;
      if (source_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL latency: source_valid=%b two cycles after eop, required 1", source_valid);
      end
      collect(8, 0, "basic");
      post_check("basic");
   endtask

   task automatic test_stall();
      build(8, 0);
      send(0, nb);
      collect(8, 1, "stall");
      post_check("stall");
   endtask

   task automatic test_long();
      build(2048, 0);
      source_ready = 1'b1;
      send(0, nb);
      collect(2048, 0, "n2048");
      post_check("n2048");
   endtask

   task automatic test_length_error();
      build(8, 0);
      b_eop[3] = 1'b1;
      send(0, 4);
      collect(8, 0, "early_eop");
      post_check("early_eop");
      build(4, 1);
      b_eop[2] = 1'b0;
      send(0, 3);
      collect(4, 2, "missing_eop");
      post_check("missing_eop");
      build(8, 1);
      send(0, nb);
      collect(8, 0, "after_err");
      post_check("after_err");
   endtask

   task automatic test_reset_mid();
      build(8, 1);
      send(0, nb);
      collect(3, 0, "pre_reset");
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      m_act = 0;
      #1;
      check_zero("mid_reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_tests++;
      if (sink_ready !== 1'b1 || source_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset_release: sink_ready=%b source_valid=%b, required 1 and 0",
                  sink_ready, source_valid);
      end
      build(4, 0);
      send(0, nb);
      collect(4, 0, "after_reset");
      post_check("after_reset");
   endtask

   task automatic test_restart();
      build(8, 1);
      send(0, 2);
      build(8, 1);
      send(0, nb);
      collect(8, 0, "restart");
      post_check("restart");
   endtask

   task automatic test_back_to_back();
      for (int p = 0; p < 4; p++) begin
         build(4 << $urandom_range(0, 5), 1);
         send(0, nb);
         collect(pk_n, 2, "random");
      end
      post_check("random");
   endtask

   initial begin
      rst_n         = 1'b0;
      sink_valid    = 1'b0;
      sink_error    = 2'b00;
      sink_sop      = 1'b0;
      sink_eop      = 1'b0;
      sink_real     = '0;
      sink_imag     = '0;
      sink_real_rev = '0;
      sink_imag_rev = '0;
      fftpts_in     = '0;
      source_ready  = 1'b1;
      test_reset();
      test_basic();
      test_stall();
      test_long();
      test_length_error();
      test_reset_mid();
      test_restart();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
